// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer/arbiter: opcodes and FSM states.
package alu_pkg;

    // ALU select encodings, passed straight through to alu_s
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_NAND  = 2'b10;
    localparam logic [1:0] OP_PASSA = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker. A lone valid requester always wins;
// when both are valid the priority pointer decides.
module rr_arb2
    import alu_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       prio,
    output logic [1:0] gnt,
    output logic       owner
);

    // Select the owner index and its one-hot grant (no grant when idle)
    always_comb begin
        owner = 1'b0;
        gnt   = 2'b00;
        if (valid0 && valid1) begin
            owner = prio;
        end else if (valid1) begin
            owner = 1'b1;
        end
        if (valid0 || valid1) begin
            gnt = owner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Sequencer that shares one external combinational 2-bit ALU between two
// valid/ready requesters. One operation at a time: IDLE -> EXEC -> RESP.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_a,
    input  logic [1:0]       req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_a,
    input  logic [1:0]       req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [3:0]       rsp0_y,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [3:0]       rsp1_y,
    output logic [1:0]       alu_a,
    output logic [1:0]       alu_b,
    output logic [1:0]       alu_s,
    input  logic [3:0]       alu_y,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1,
    output logic             busy
);

    state_t     state;
    logic       prio;
    logic       owner_q;
    logic [1:0] opnd_a;
    logic [1:0] opnd_b;
    logic [1:0] opnd_op;
    logic [3:0] result;
    logic [1:0] gnt;
    logic       owner;
    logic       rsp_fire;

    // Counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    rr_arb2 u_arb (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .prio   (prio),
        .gnt    (gnt),
        .owner  (owner)
    );

    // Ready only in IDLE and only for the picked requester (which implies its valid)
    assign req0_ready = (state == ST_IDLE) && gnt[0];
    assign req1_ready = (state == ST_IDLE) && gnt[1];

    // ALU is always driven from the operand registers, which hold between ops
    assign alu_a = opnd_a;
    assign alu_b = opnd_b;
    assign alu_s = opnd_op;

    // Result is visible only on the owner's channel while its valid is up
    assign rsp0_y = rsp0_valid ? result : 4'd0;
    assign rsp1_y = rsp1_valid ? result : 4'd0;

    assign rsp_fire = owner_q ? rsp1_ready : rsp0_ready;

    // Sequencer FSM with registered operands, result, counters and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            prio       <= 1'b0;
            owner_q    <= 1'b0;
            opnd_a     <= 2'd0;
            opnd_b     <= 2'd0;
            opnd_op    <= 2'd0;
            result     <= 4'd0;
            gnt_cnt0   <= '0;
            gnt_cnt1   <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        opnd_a  <= owner ? req1_a  : req0_a;
                        opnd_b  <= owner ? req1_b  : req0_b;
                        opnd_op <= owner ? req1_op : req0_op;
                        owner_q <= owner;
                        if (owner) begin
                            gnt_cnt1 <= sat_inc(gnt_cnt1);
                        end else begin
                            gnt_cnt0 <= sat_inc(gnt_cnt0);
                        end
                        busy  <= 1'b1;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result <= alu_y;
                    if (owner_q) begin
                        rsp1_valid <= 1'b1;
                    end else begin
                        rsp0_valid <= 1'b1;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_fire) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        prio       <= ~owner_q;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model
// that is compared against every output on every falling clock edge.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [1:0]       req0_a = 2'd0, req0_b = 2'd0, req0_op = 2'd0;
    logic [1:0]       req1_a = 2'd0, req1_b = 2'd0, req1_op = 2'd0;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [3:0]       rsp0_y, rsp1_y;
    logic [1:0]       alu_a, alu_b, alu_s;
    logic [3:0]       alu_y;
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .busy(busy)
    );

    // What the shared ALU computes for an opcode and operand pair
    function automatic logic [3:0] alu_fn(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
        case (op)
            OP_MULT: return {2'b00, a} * {2'b00, b};
            OP_ADD:  return {2'b00, a} + {2'b00, b};
            OP_NAND: return {2'b00, ~(a & b)};
            default: return {2'b00, a};
        endcase
    endfunction

    // External ALU stand-in
    assign alu_y = alu_fn(alu_s, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Who wins among the currently valid requesters (-1 if none)
    function automatic int winner(input logic v0, input logic v1, input int pr);
        if (v0 && v1) return pr;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Reference model: one transaction in flight, identified by its owner and
    // the number of edges since it was accepted.
    int         m_own;      // -1 when no transaction is in flight
    int         m_age;      // 0: cycle after accept, >=1: response offered
    int         m_prio;
    int         m_cnt0, m_cnt1;
    logic [3:0] m_res;
    logic [1:0] m_a, m_b, m_op;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own <= -1; m_age <= 0; m_prio <= 0;
            m_cnt0 <= 0; m_cnt1 <= 0; m_res <= 4'd0;
            m_a <= 2'd0; m_b <= 2'd0; m_op <= 2'd0;
        end else if (m_own < 0) begin
            if (winner(req0_valid, req1_valid, m_prio) == 0) begin
                m_own <= 0; m_age <= 0;
                m_a <= req0_a; m_b <= req0_b; m_op <= req0_op;
                m_res <= alu_fn(req0_op, req0_a, req0_b);
                m_cnt0 <= (m_cnt0 == CNT_MAX) ? CNT_MAX : m_cnt0 + 1;
            end else if (winner(req0_valid, req1_valid, m_prio) == 1) begin
                m_own <= 1; m_age <= 0;
                m_a <= req1_a; m_b <= req1_b; m_op <= req1_op;
                m_res <= alu_fn(req1_op, req1_a, req1_b);
                m_cnt1 <= (m_cnt1 == CNT_MAX) ? CNT_MAX : m_cnt1 + 1;
            end
        end else if (m_age == 0) begin
            m_age <= 1;
        end else if ((m_own == 0 && rsp0_ready) || (m_own == 1 && rsp1_ready)) begin
            m_prio <= 1 - m_own;
            m_own  <= -1;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge clk) begin
        int  w;
        logic e0, e1;
        w  = winner(req0_valid, req1_valid, m_prio);
        e0 = (m_own == 0) && (m_age >= 1);
        e1 = (m_own == 1) && (m_age >= 1);
        chk("m_req0_ready", req0_ready, (m_own < 0) && (w == 0));
        chk("m_req1_ready", req1_ready, (m_own < 0) && (w == 1));
        chk("m_rsp0_valid", rsp0_valid, e0);
        chk("m_rsp1_valid", rsp1_valid, e1);
        chk("m_rsp0_y", rsp0_y, e0 ? m_res : 4'd0);
        chk("m_rsp1_y", rsp1_y, e1 ? m_res : 4'd0);
        chk("m_alu_a", alu_a, m_a);
        chk("m_alu_b", alu_b, m_b);
        chk("m_alu_s", alu_s, m_op);
        chk("m_gnt_cnt0", gnt_cnt0, m_cnt0);
        chk("m_gnt_cnt1", gnt_cnt1, m_cnt1);
        chk("m_busy", busy, m_own >= 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Present a request (called just after a rising edge) and drop it after acceptance
    task automatic send(input int idx, input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
        bit found;
        found = 1'b0;
        if (idx == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((idx == 0 && req0_ready) || (idx == 1 && req1_ready)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("accept_timeout", found, 1'b1);
        step();
        if (idx == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    // Wait (bounded) for a response; report owner, value and falling edges waited
    task automatic wait_rsp(output int who, output logic [3:0] y, output int n);
        who = -1; y = 4'd0; n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (rsp0_valid) begin who = 0; y = rsp0_y; break; end
            if (rsp1_valid) begin who = 1; y = rsp1_y; break; end
        end
        chk("rsp_timeout", (who >= 0), 1'b1);
    endtask

    initial begin
        int         who, n;
        logic [3:0] y;
        int         sat_exp [5] = '{1, 2, 3, 3, 3};

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp0_valid", rsp0_valid, 1'b0);
        chk("rst_rsp1_y", rsp1_y, 4'd0);
        chk("rst_alu_s", alu_s, 2'd0);
        chk("rst_gnt_cnt0", gnt_cnt0, 0);
        do_reset();

        // Single request: 3*3
        rsp0_ready = 1'b1;
        send(0, 2'd3, 2'd3, OP_MULT);
        @(negedge clk);
        chk("single_exec_alu_s", alu_s, OP_MULT);
        chk("single_exec_busy", busy, 1'b1);
        chk("single_exec_novalid", rsp0_valid, 1'b0);
        wait_rsp(who, y, n);
        chk("single_owner", who, 0);
        chk("single_y", y, 4'd9);
        chk("single_latency", n, 1);
        chk("single_cnt0", gnt_cnt0, 1);
        step();

        // Contention from reset: both valid, prio starts at requester 0
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_a = 2'd2; req0_b = 2'd1; req0_op = OP_ADD;
        req1_a = 2'd1; req1_b = 2'd2; req1_op = OP_NAND;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("cont_req0_ready", req0_ready, 1'b1);
        chk("cont_req1_ready", req1_ready, 1'b0);
        wait_rsp(who, y, n);
        chk("cont1_owner", who, 0);
        chk("cont1_y", y, 4'd3);
        wait_rsp(who, y, n);
        chk("cont2_owner", who, 1);
        chk("cont2_y", y, 4'b0011);
        wait_rsp(who, y, n);
        chk("cont3_owner", who, 0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Back-pressure on requester 1 while requester 0 waits
        do_reset();
        send(1, 2'd2, 2'd0, OP_PASSA);
        req0_valid = 1'b1; req0_a = 2'd1; req0_b = 2'd1; req0_op = OP_ADD;
        wait_rsp(who, y, n);
        chk("bp_owner", who, 1);
        chk("bp_y", y, 4'd2);
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk("bp_hold_valid", rsp1_valid, 1'b1);
            chk("bp_hold_y", rsp1_y, 4'd2);
            chk("bp_req0_blocked", req0_ready, 1'b0);
        end
        step();
        rsp1_ready = 1'b1;
        step();
        rsp1_ready = 1'b0;
        @(negedge clk);
        chk("bp_done_valid", rsp1_valid, 1'b0);
        chk("bp_next_accept", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        rsp0_ready = 1'b1;
        wait_rsp(who, y, n);
        chk("bp_next_owner", who, 0);
        chk("bp_next_y", y, 4'd2);
        step();

        // Asynchronous reset during EXEC
        do_reset();
        send(0, 2'd3, 2'd2, OP_ADD);
        @(negedge clk);
        chk("ar_in_exec", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 1'b0);
        chk("ar_rsp0_valid", rsp0_valid, 1'b0);
        chk("ar_alu_a", alu_a, 2'd0);
        chk("ar_alu_b", alu_b, 2'd0);
        chk("ar_gnt_cnt0", gnt_cnt0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rsp0_ready = 1'b1;
        send(0, 2'd1, 2'd2, OP_MULT);
        wait_rsp(who, y, n);
        chk("ar_after_owner", who, 0);
        chk("ar_after_y", y, 4'd2);
        chk("ar_after_cnt0", gnt_cnt0, 1);
        step();

        // Counter saturation at CNT_W=2
        do_reset();
        rsp0_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            send(0, 2'd1, 2'd1, OP_ADD);
            wait_rsp(who, y, n);
            chk("sat_y", y, 4'd2);
            chk("sat_cnt0", gnt_cnt0, sat_exp[i]);
        end
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
